// File: rtl/imm_gen_stage_if.sv
// Handshake/result bundle between fetch, imm_gen_stage and decode/execute.
// The slave view is the stage itself; the master view is the surrounding pipeline.
interface imm_gen_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic [XLEN-1:0] out_target;
   logic            out_unknown;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_target, out_unknown
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_target, out_unknown
   );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate generator + PC-relative target adder behind a 2-entry skid buffer.
// XLEN must be 32 or 64. Define IMM_GEN_ZICSR_EN to decode SYSTEM/CSR immediates.
module imm_gen_stage #(
   parameter int XLEN = 32
) (
   input logic            clk,
   input logic            rst_n,
   input logic            flush,
   imm_gen_stage_if.slave bus
);

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      fmt_e            fmt;
      logic            unknown;
   } result_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic [31:0]     instr;
   logic [6:0]      opcode;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            pc_rel;
   result_t         dec;

   result_t main_q, skid_q;
   logic    main_valid, skid_valid;
   logic    accept, main_load;

   assign instr  = bus.in_instr;
   assign opcode = instr[6:0];

   // Sized casts of signed values sign-extend from instr[31] to XLEN.
   assign imm_i = XLEN'($signed(instr[31:20]));
   assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
   assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

`ifdef IMM_GEN_ZICSR_EN
   logic [2:0] funct3;
   assign funct3 = instr[14:12];
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      dec     = '0;
      pc_rel  = 1'b0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR: begin
            dec.imm = imm_i;
            dec.fmt = FMT_I;
         end
         OP_IMM32: begin
            if (XLEN == 64) begin
               dec.imm = imm_i;
               dec.fmt = FMT_I;
            end else begin
               dec.unknown = 1'b1;
            end
         end
         OP_STORE: begin
            dec.imm = imm_s;
            dec.fmt = FMT_S;
         end
         OP_BRANCH: begin
            dec.imm = imm_b;
            dec.fmt = FMT_B;
            pc_rel  = 1'b1;
         end
         OP_LUI: begin
            dec.imm = imm_u;
            dec.fmt = FMT_U;
         end
         OP_AUIPC: begin
            dec.imm = imm_u;
            dec.fmt = FMT_U;
            pc_rel  = 1'b1;
         end
         OP_JAL: begin
            dec.imm = imm_j;
            dec.fmt = FMT_J;
            pc_rel  = 1'b1;
         end
         OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
            case (funct3)
               3'b101, 3'b110, 3'b111: begin
                  dec.imm = XLEN'(instr[19:15]);
                  dec.fmt = FMT_Z;
               end
               3'b001, 3'b010, 3'b011: begin
                  dec.imm = XLEN'(instr[31:20]);
                  dec.fmt = FMT_I;
               end
               3'b100:  dec.unknown = 1'b1;
               default: dec.unknown = 1'b0;
            endcase
`else
            dec.unknown = 1'b1;
`endif
         end
         default: dec.unknown = 1'b1;
      endcase
      // JALR stays at zero: rs1 is not visible in this stage.
      dec.target = pc_rel ? (bus.in_pc + dec.imm) : '0;
   end

   // SKID empty is the only admission condition, so in_ready is a pure flop output.
   assign accept    = bus.in_valid && !skid_valid;
   assign main_load = !main_valid || bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the payload registers are reset too; they drive the outputs directly and must read 0 after reset.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_load) begin
         // NOTE: non-blocking updates let MAIN take the old SKID value while SKID clears on the same edge.
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            main_valid <= accept;
            if (accept) main_q <= dec;
         end
      end else if (accept) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign bus.in_ready    = !skid_valid;
   assign bus.out_valid   = main_valid;
   assign bus.out_imm     = main_q.imm;
   assign bus.out_fmt     = main_q.fmt;
   assign bus.out_target  = main_q.target;
   assign bus.out_unknown = main_q.unknown;

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined, XLEN-parametrised immediate generator with a valid/ready elastic stage and a built-in PC-relative target adder. It sits between fetch and decode/execute. Each accepted instruction produces one registered result:
- the sign-extended immediate,
- the format code,
- the PC + immediate target for branch, jump and AUIPC,
- an unknown-opcode flag.

A 2-entry skid buffer gives full throughput under backpressure with a registered `in_ready`.

## Interface
- `XLEN`, 32 — datapath width; legal values are 32 and 64 only.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `flush` input 1 — synchronous kill of all buffered entries.
- `in_valid` input 1 — upstream has an instruction.
- `in_ready` output 1 — stage can accept; registered.
- `in_instr` input 32 — raw instruction word.
- `in_pc` input XLEN — address of `in_instr`.
- `out_valid` output 1 — result available.
- `out_ready` input 1 — downstream accepts the result.
- `out_imm` output XLEN — extended immediate.
- `out_fmt` output 3 — format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- `out_target` output XLEN — `in_pc + out_imm` for B, J and AUIPC; 0 otherwise.
- `out_unknown` output 1 — opcode not recognised; `out_imm` = 0, `out_fmt` = 0.

## Operation
Decode is by `opcode = instr[6:0]`. All sign extension is from `instr[31]` to XLEN.
- **I format:** LOAD 0000011, OP-IMM 0010011, JALR 1100111, and OP-IMM-32 0011011 (XLEN=64 only; unknown at XLEN=32). Immediate = `instr[31:20]`.
- **S format:** STORE 0100011. Immediate = `{instr[31:25], instr[11:7]}`.
- **B format:** BRANCH 1100011. Immediate = `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
- **U format:** LUI 0110111 and AUIPC 0010111. Immediate = `{instr[31:12], 12'b0}`, sign-extended at XLEN=64.
- **J format:** JAL 1101111. Immediate = `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
- **SYSTEM 1110011:** handled per Configuration.
- **Any other opcode:** `out_unknown` = 1.
- **Target adder:** addition is modulo 2^XLEN; there is no overflow flag. JALR target = 0, because rs1 is not available here.
- **Storage:** a main output register (MAIN) plus one skid register (SKID), each with its own valid bit. The `in_ready` register is 1 exactly when SKID is empty.

## Timing
- **Reset:** `out_valid`=0, `in_ready`=1, `out_imm`/`out_target`/`out_fmt`=0, `out_unknown`=0, SKID empty. Reset acts immediately on assertion, including mid-transfer; all entries are discarded.
- **Accept and latency:** an input is accepted on a rising edge with `in_valid && in_ready`. Its result appears in MAIN on the next edge, giving 1-cycle latency when MAIN is empty or draining.
- **MAIN loads** when (`!out_valid || out_ready`):
  - from SKID if SKID is valid;
  - otherwise from the accepted input.
- **Accept while stalled:** if an input is accepted while `out_valid && !out_ready`, it goes to SKID, and `in_ready` = 0 from the next cycle.
- **Drain:** when SKID drains into MAIN (`out_ready`=1), `in_ready` = 1 from the next cycle. An input offered in that same cycle is not accepted, because `in_ready` was 0.
- **Throughput:** one result per cycle when `out_ready` is held at 1. No bubble is inserted.
- **Data stability:** output data must stay stable while `out_valid && !out_ready`.
- **Flush:** clears both valids on the edge. `in_ready` = 1 next cycle. Flush overrides a simultaneous accept: that input is dropped and not counted as accepted.
- **Combinational paths:** none from `out_ready` to `in_ready`, and none from `in_*` to `out_*`.

## Configuration
- Macro: `IMM_GEN_ZICSR_EN`.
- **Defined** — SYSTEM opcode is decoded by `funct3`:
  - 101, 110, 111: `out_fmt`=6, `out_imm` = zero-extended `instr[19:15]`.
  - 001, 010, 011: `out_fmt`=1, `out_imm` = zero-extended `instr[31:20]` (CSR address).
  - 000: `out_fmt`=0, `out_imm`=0, `out_unknown`=0.
  - 100: `out_unknown`=1.
- **Undefined:** SYSTEM is treated as unknown (`out_unknown`=1, `out_imm`=0).

## Test plan
- **Branch, XLEN=32:** `in_instr`=0xFE000EE3 (beq x0,x0,-4), `in_pc`=0x100 -> next cycle `out_imm`=0xFFFFFFFC, `out_fmt`=3, `out_target`=0xFC.
- **JAL:** `in_instr`=0x001000EF (jal x1,+2048), `in_pc`=0x1000 -> `out_imm`=0x800, `out_fmt`=5, `out_target`=0x1800.
- **LUI, XLEN=64:** `in_instr`=0xFFFFF2B7 (lui x5,0xFFFFF) -> `out_imm`=0xFFFFFFFFFFFFF000, `out_fmt`=4, `out_target`=0. Separately, `in_instr`=0x0000001B at XLEN=32 -> `out_unknown`=1.
- **Backpressure:**
  - Hold `out_ready`=0 and stream 3 instructions -> 2 accepted, `in_ready`=0 from cycle 2.
  - Then raise `out_ready` -> results emerge in order, 1 per cycle, with no loss or duplication.
  - Randomised ready/valid run checked against a scoreboard.
- **Flush and reset:**
  - Fill MAIN+SKID, then assert `flush` with `in_valid`=1 -> next cycle `out_valid`=0 and `in_ready`=1; the flushed and concurrent entries never appear.
  - Deassert `rst_n` mid-stream -> outputs are immediately at reset values.
- **CSR:** `in_instr`=0x300FD0F3 (csrrwi x1,0x300,31)
  - with `IMM_GEN_ZICSR_EN` -> `out_imm`=31, `out_fmt`=6;
  - without it -> `out_unknown`=1, `out_imm`=0.
